// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: shared definitions for the button-driven time/alarm setter.
//   - edit_state_e : FSM state encoding, also exported on EDIT_STATE
//   - time_field_t : 6-bit hour/minute field
//   - MAX_HORA / MAX_MIN : highest legal hour/minute values
//   - wrap_inc / wrap_dec / clamp_field : edit-field arithmetic helpers
package time_set_ctrl_pkg;

    typedef logic [5:0] time_field_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        ALM_H = 3'd3,
        ALM_M = 3'd4
    } edit_state_e;

    localparam time_field_t MAX_HORA = 6'd23;
    localparam time_field_t MAX_MIN  = 6'd59;

    // Step up, rolling over from max_v to zero.
    function automatic time_field_t wrap_inc(input time_field_t v, input time_field_t max_v);
        if (v >= max_v) begin
            return 6'd0;
        end else begin
            return v + 6'd1;
        end
    endfunction

    // Step down, rolling over from zero to max_v.
    function automatic time_field_t wrap_dec(input time_field_t v, input time_field_t max_v);
        if ((v == 6'd0) || (v > max_v)) begin
            return max_v;
        end else begin
            return v - 6'd1;
        end
    endfunction

    // Out-of-range readback values are replaced by zero.
    function automatic time_field_t clamp_field(input time_field_t v, input time_field_t max_v);
        if (v > max_v) begin
            return 6'd0;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge_repeat.sv
// btn_edge_repeat: press detector with optional hold-to-repeat for one button.
// Optional feature macro: TIME_SET_AUTO_REPEAT_EN (repeat counter present only when defined).
// Ports:
//   CLK    in  system clock
//   RESET  in  synchronous active-high reset
//   BTN    in  button level, already synchronised to CLK
//   PRESS  out combinational press pulse (BTN high, previous sample low)
//   STEP   out PRESS, plus repeat steps while held when auto-repeat is built in
module btn_edge_repeat #(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN,
    output logic PRESS,
    output logic STEP
);

    logic prev_r;

    // previous-sample register for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= BTN;
        end
    end

    assign PRESS = BTN & ~prev_r;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);

    logic [CW-1:0] rep_cnt_r;
    logic          repeating_r;
    logic          held_s;
    logic          rep_due_s;

    // held_s is false on the press cycle itself, so the first repeat lands
    // REPEAT_DELAY cycles after the press step.
    assign held_s    = BTN & prev_r & REPEAT_EN;
    assign rep_due_s = held_s && (repeating_r ? (rep_cnt_r == CW'(REPEAT_RATE - 1))
                                              : (rep_cnt_r == CW'(REPEAT_DELAY - 1)));

    // hold-time counter: first the initial delay, then the repeat period
    always_ff @(posedge CLK) begin
        if (RESET || !held_s) begin
            rep_cnt_r   <= {CW{1'b0}};
            repeating_r <= 1'b0;
        end else if (rep_due_s) begin
            rep_cnt_r   <= {CW{1'b0}};
            repeating_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_r + CW'(1);
            repeating_r <= repeating_r;
        end
    end

    assign STEP = PRESS | rep_due_s;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{REPEAT_DELAY[0], REPEAT_RATE[0], REPEAT_EN};
    assign STEP = PRESS;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button front end producing time-load and alarm-target
// values for the running clock counter.
// Optional feature macro: TIME_SET_AUTO_REPEAT_EN (hold UP/DOWN to auto-repeat).
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   BTN_MODE/UP/DOWN/OK              synchronised button levels
//   CUR_HORAS, CUR_MINUTOS           running time, preloaded into a time edit
//   IHORAS, IMINUTOS, SET_HORA       committed time and its one-cycle load strobe
//   THORAS, TMINUTOS, ALM_UPD        alarm target and its one-cycle update strobe
//   EDIT_STATE, EDIT_HORAS/MINUTOS   FSM state and in-progress edit values
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter int TIMEOUT      = 1000,
    parameter int ALARM_H_RST  = 6,
    parameter int ALARM_M_RST  = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_OK,
    input  logic [5:0] CUR_HORAS,
    input  logic [5:0] CUR_MINUTOS,
    output logic [5:0] IHORAS,
    output logic [5:0] IMINUTOS,
    output logic       SET_HORA,
    output logic [5:0] THORAS,
    output logic [5:0] TMINUTOS,
    output logic       ALM_UPD,
    output logic [2:0] EDIT_STATE,
    output logic [5:0] EDIT_HORAS,
    output logic [5:0] EDIT_MINUTOS
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    edit_state_e   state_r, state_nxt_s;
    time_field_t   edit_h_r, edit_h_nxt_s, edit_m_r, edit_m_nxt_s;
    time_field_t   ih_r, ih_nxt_s, im_r, im_nxt_s;
    time_field_t   th_r, th_nxt_s, tm_r, tm_nxt_s;
    logic          set_r, set_nxt_s, alm_r, alm_nxt_s;
    logic [TW-1:0] to_cnt_r, to_cnt_nxt_s;
    logic          mode_press_s, ok_press_s, up_press_s, down_press_s;
    logic          up_step_s, down_step_s, any_evt_s, hour_field_s;
    logic          mode_step_unused_s, ok_step_unused_s;

    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_mode (.CLK(CLK), .RESET(RESET), .BTN(BTN_MODE), .PRESS(mode_press_s), .STEP(mode_step_unused_s));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0))
        u_ok   (.CLK(CLK), .RESET(RESET), .BTN(BTN_OK), .PRESS(ok_press_s), .STEP(ok_step_unused_s));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_up   (.CLK(CLK), .RESET(RESET), .BTN(BTN_UP), .PRESS(up_press_s), .STEP(up_step_s));
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1))
        u_down (.CLK(CLK), .RESET(RESET), .BTN(BTN_DOWN), .PRESS(down_press_s), .STEP(down_step_s));

    // Any press or repeat step counts as activity for the inactivity timeout.
    assign any_evt_s    = mode_press_s | ok_press_s | up_press_s | down_press_s | up_step_s | down_step_s;
    assign hour_field_s = (state_r == SET_H) || (state_r == ALM_H);

    // next-state and next-output logic; priority OK > MODE > UP/DOWN > timeout
    always_comb begin
        state_nxt_s  = state_r;
        edit_h_nxt_s = edit_h_r;
        edit_m_nxt_s = edit_m_r;
        ih_nxt_s     = ih_r;
        im_nxt_s     = im_r;
        th_nxt_s     = th_r;
        tm_nxt_s     = tm_r;
        set_nxt_s    = 1'b0;
        alm_nxt_s    = 1'b0;

        if ((state_r == IDLE) || any_evt_s) begin
            to_cnt_nxt_s = {TW{1'b0}};
        end else begin
            to_cnt_nxt_s = to_cnt_r + TW'(1);
        end

        case (state_r)
            IDLE: begin
                if (mode_press_s) begin
                    state_nxt_s  = SET_H;
                    edit_h_nxt_s = clamp_field(CUR_HORAS, MAX_HORA);
                    edit_m_nxt_s = clamp_field(CUR_MINUTOS, MAX_MIN);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SET_H, SET_M, ALM_H, ALM_M: begin
                if (ok_press_s) begin
                    state_nxt_s = IDLE;
                    if ((state_r == SET_H) || (state_r == SET_M)) begin
                        ih_nxt_s  = edit_h_r;
                        im_nxt_s  = edit_m_r;
                        set_nxt_s = 1'b1;
                    end else begin
                        th_nxt_s  = edit_h_r;
                        tm_nxt_s  = edit_m_r;
                        alm_nxt_s = 1'b1;
                    end
                end else if (mode_press_s) begin
                    case (state_r)
                        SET_H: state_nxt_s = SET_M;
                        SET_M: begin
                            // leaving the time edit uncommitted; alarm edit starts from the target
                            state_nxt_s  = ALM_H;
                            edit_h_nxt_s = th_r;
                            edit_m_nxt_s = tm_r;
                        end
                        ALM_H:   state_nxt_s = ALM_M;
                        default: state_nxt_s = IDLE;
                    endcase
                end else if (up_step_s != down_step_s) begin
                    if (hour_field_s) begin
                        edit_h_nxt_s = up_step_s ? wrap_inc(edit_h_r, MAX_HORA) : wrap_dec(edit_h_r, MAX_HORA);
                    end else begin
                        edit_m_nxt_s = up_step_s ? wrap_inc(edit_m_r, MAX_MIN) : wrap_dec(edit_m_r, MAX_MIN);
                    end
                end else if (!any_evt_s && (to_cnt_r == TO_LAST)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // state, edit, committed-value and strobe registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= IDLE;
            edit_h_r <= 6'd0;
            edit_m_r <= 6'd0;
            ih_r     <= 6'd0;
            im_r     <= 6'd0;
            th_r     <= time_field_t'(ALARM_H_RST);
            tm_r     <= time_field_t'(ALARM_M_RST);
            set_r    <= 1'b0;
            alm_r    <= 1'b0;
            to_cnt_r <= {TW{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            edit_h_r <= edit_h_nxt_s;
            edit_m_r <= edit_m_nxt_s;
            ih_r     <= ih_nxt_s;
            im_r     <= im_nxt_s;
            th_r     <= th_nxt_s;
            tm_r     <= tm_nxt_s;
            set_r    <= set_nxt_s;
            alm_r    <= alm_nxt_s;
            to_cnt_r <= to_cnt_nxt_s;
        end
    end

    assign IHORAS       = ih_r;
    assign IMINUTOS     = im_r;
    assign SET_HORA     = set_r;
    assign THORAS       = th_r;
    assign TMINUTOS     = tm_r;
    assign ALM_UPD      = alm_r;
    assign EDIT_STATE   = state_r;
    assign EDIT_HORAS   = edit_h_r;
    assign EDIT_MINUTOS = edit_m_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: self-checking bench for time_set_ctrl.
// Table-driven directed vectors, hand-written timeout/reset/repeat sequences,
// then random button activity compared against a behavioural model.
// Honours TIME_SET_AUTO_REPEAT_EN the same way the design does.
module tb_time_set_ctrl;

    localparam int DLY  = 50;
    localparam int RATE = 10;
    localparam int TO   = 1000;

    localparam logic [3:0] BZ = 4'b0000;
    localparam logic [3:0] BM = 4'b1000;
    localparam logic [3:0] BU = 4'b0100;
    localparam logic [3:0] BD = 4'b0010;
    localparam logic [3:0] BO = 4'b0001;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTN_MODE = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_OK = 1'b0;
    logic [5:0] CUR_HORAS = 6'd0, CUR_MINUTOS = 6'd0;
    logic [5:0] IHORAS, IMINUTOS, THORAS, TMINUTOS, EDIT_HORAS, EDIT_MINUTOS;
    logic       SET_HORA, ALM_UPD;
    logic [2:0] EDIT_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    time_set_ctrl #(
        .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .TIMEOUT(TO),
        .ALARM_H_RST(6), .ALARM_M_RST(0)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_OK(BTN_OK),
        .CUR_HORAS(CUR_HORAS), .CUR_MINUTOS(CUR_MINUTOS),
        .IHORAS(IHORAS), .IMINUTOS(IMINUTOS), .SET_HORA(SET_HORA),
        .THORAS(THORAS), .TMINUTOS(TMINUTOS), .ALM_UPD(ALM_UPD),
        .EDIT_STATE(EDIT_STATE), .EDIT_HORAS(EDIT_HORAS), .EDIT_MINUTOS(EDIT_MINUTOS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state, m_eh, m_em, m_ih, m_im, m_th, m_tm, m_set, m_alm, m_idle;
    logic [3:0] m_prev;
`ifdef TIME_SET_AUTO_REPEAT_EN
    int m_held_up, m_held_dn;

    function automatic bit repeat_hit(input int held);
        return (held == DLY) || ((held > DLY) && (((held - DLY) % RATE) == 0));
    endfunction
`endif

    function automatic void model_reset();
        m_state = 0; m_eh = 0; m_em = 0; m_ih = 0; m_im = 0;
        m_th = 6; m_tm = 0; m_set = 0; m_alm = 0; m_idle = 0; m_prev = 4'b0000;
`ifdef TIME_SET_AUTO_REPEAT_EN
        m_held_up = 0; m_held_dn = 0;
`endif
    endfunction

    // b = {MODE, UP, DOWN, OK}
    function automatic void model_step(input logic [3:0] b, input int ch, input int cm, input logic rst);
        logic [3:0] pr;
        bit up_s, dn_s, evt;
        int old;
        if (rst) begin
            model_reset();
            return;
        end
        pr   = b & ~m_prev;
        up_s = pr[2];
        dn_s = pr[1];
`ifdef TIME_SET_AUTO_REPEAT_EN
        if (b[2] && !pr[2]) begin m_held_up++; up_s = repeat_hit(m_held_up); end else m_held_up = 0;
        if (b[1] && !pr[1]) begin m_held_dn++; dn_s = repeat_hit(m_held_dn); end else m_held_dn = 0;
`endif
        m_prev = b;
        evt    = (pr != 4'b0000) || up_s || dn_s;
        m_set  = 0;
        m_alm  = 0;
        old    = m_state;
        if (old == 0) begin
            if (pr[3]) begin
                m_state = 1;
                m_eh = (ch > 23) ? 0 : ch;
                m_em = (cm > 59) ? 0 : cm;
            end
        end else if (pr[0]) begin
            if (old <= 2) begin m_ih = m_eh; m_im = m_em; m_set = 1; end
            else begin m_th = m_eh; m_tm = m_em; m_alm = 1; end
            m_state = 0;
        end else if (pr[3]) begin
            if (old == 2) begin m_eh = m_th; m_em = m_tm; end
            m_state = (old == 4) ? 0 : old + 1;
        end else if (up_s != dn_s) begin
            if ((old == 1) || (old == 3)) m_eh = up_s ? (m_eh + 1) % 24 : (m_eh + 23) % 24;
            else                          m_em = up_s ? (m_em + 1) % 60 : (m_em + 59) % 60;
        end
        if ((old == 0) || evt) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle >= TO) m_state = 0;
        end
    endfunction

    task automatic cyc(input logic [3:0] b, input int ch, input int cm, input logic rst);
        BTN_MODE = b[3]; BTN_UP = b[2]; BTN_DOWN = b[1]; BTN_OK = b[0];
        CUR_HORAS = 6'(ch); CUR_MINUTOS = 6'(cm); RESET = rst;
        @(posedge CLK);
        model_step(b, ch, cm, rst);
        #1;
    endtask

    task automatic cmp_model();
        check("rnd_state", EDIT_STATE, m_state);
        check("rnd_edit_h", EDIT_HORAS, m_eh);
        check("rnd_edit_m", EDIT_MINUTOS, m_em);
        check("rnd_ihoras", IHORAS, m_ih);
        check("rnd_imin", IMINUTOS, m_im);
        check("rnd_set_hora", SET_HORA, m_set);
        check("rnd_thoras", THORAS, m_th);
        check("rnd_tmin", TMINUTOS, m_tm);
        check("rnd_alm_upd", ALM_UPD, m_alm);
    endtask

    task automatic cmp_reset_vals(input string tag);
        check({tag, "_state"}, EDIT_STATE, 0);
        check({tag, "_edit_h"}, EDIT_HORAS, 0);
        check({tag, "_edit_m"}, EDIT_MINUTOS, 0);
        check({tag, "_ihoras"}, IHORAS, 0);
        check({tag, "_imin"}, IMINUTOS, 0);
        check({tag, "_set_hora"}, SET_HORA, 0);
        check({tag, "_thoras"}, THORAS, 6);
        check({tag, "_tmin"}, TMINUTOS, 0);
        check({tag, "_alm_upd"}, ALM_UPD, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] btn;
        int ch, cm;
        int st, eh, em, ih, im, set, th, tm, alm;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [3:0] b, input int ch, input int cm, input int st,
                                input int eh, input int em, input int ih, input int im,
                                input int set, input int th, input int tm, input int alm);
        vec_t v;
        v.btn = b; v.ch = ch; v.cm = cm; v.st = st; v.eh = eh; v.em = em;
        v.ih = ih; v.im = im; v.set = set; v.th = th; v.tm = tm; v.alm = alm;
        vecs.push_back(v);
    endfunction

    initial begin
        int strobes;
        logic [3:0] rb;
        int rch, rcm;

        // time edit from 23:59 with hour wrap 23->0
        add(BM, 23, 59, 1, 23, 59,  0,  0, 0, 6,  0, 0);
        add(BZ, 23, 59, 1, 23, 59,  0,  0, 0, 6,  0, 0);
        add(BU, 23, 59, 1,  0, 59,  0,  0, 0, 6,  0, 0);
        add(BZ, 23, 59, 1,  0, 59,  0,  0, 0, 6,  0, 0);
        add(BO, 23, 59, 0,  0, 59,  0, 59, 1, 6,  0, 0);
        add(BZ, 23, 59, 0,  0, 59,  0, 59, 0, 6,  0, 0);
        // minute DOWN wrap 0->59
        add(BM, 10,  0, 1, 10,  0,  0, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 1, 10,  0,  0, 59, 0, 6,  0, 0);
        add(BM, 10,  0, 2, 10,  0,  0, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 2, 10,  0,  0, 59, 0, 6,  0, 0);
        add(BD, 10,  0, 2, 10, 59,  0, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 2, 10, 59,  0, 59, 0, 6,  0, 0);
        add(BO, 10,  0, 0, 10, 59, 10, 59, 1, 6,  0, 0);
        add(BZ, 10,  0, 0, 10, 59, 10, 59, 0, 6,  0, 0);
        // alarm edit from 06:00
        add(BM, 10,  0, 1, 10,  0, 10, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 1, 10,  0, 10, 59, 0, 6,  0, 0);
        add(BM, 10,  0, 2, 10,  0, 10, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 2, 10,  0, 10, 59, 0, 6,  0, 0);
        add(BM, 10,  0, 3,  6,  0, 10, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 3,  6,  0, 10, 59, 0, 6,  0, 0);
        add(BU, 10,  0, 3,  7,  0, 10, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 3,  7,  0, 10, 59, 0, 6,  0, 0);
        add(BM, 10,  0, 4,  7,  0, 10, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 4,  7,  0, 10, 59, 0, 6,  0, 0);
        add(BD, 10,  0, 4,  7, 59, 10, 59, 0, 6,  0, 0);
        add(BZ, 10,  0, 4,  7, 59, 10, 59, 0, 6,  0, 0);
        add(BO, 10,  0, 0,  7, 59, 10, 59, 0, 7, 59, 1);
        add(BZ, 10,  0, 0,  7, 59, 10, 59, 0, 7, 59, 0);
        // UP+DOWN together: no step; OK+MODE together: commit
        add(BM,  5, 30, 1,  5, 30, 10, 59, 0, 7, 59, 0);
        add(BZ,  5, 30, 1,  5, 30, 10, 59, 0, 7, 59, 0);
        add(BU | BD, 5, 30, 1, 5, 30, 10, 59, 0, 7, 59, 0);
        add(BZ,  5, 30, 1,  5, 30, 10, 59, 0, 7, 59, 0);
        add(BO | BM, 5, 30, 0, 5, 30,  5, 30, 1, 7, 59, 0);
        add(BZ,  5, 30, 0,  5, 30,  5, 30, 0, 7, 59, 0);
        // hour DOWN wrap 0->23, minute UP wrap 59->0
        add(BM,  0, 59, 1,  0, 59,  5, 30, 0, 7, 59, 0);
        add(BZ,  0, 59, 1,  0, 59,  5, 30, 0, 7, 59, 0);
        add(BD,  0, 59, 1, 23, 59,  5, 30, 0, 7, 59, 0);
        add(BZ,  0, 59, 1, 23, 59,  5, 30, 0, 7, 59, 0);
        add(BM,  0, 59, 2, 23, 59,  5, 30, 0, 7, 59, 0);
        add(BZ,  0, 59, 2, 23, 59,  5, 30, 0, 7, 59, 0);
        add(BU,  0, 59, 2, 23,  0,  5, 30, 0, 7, 59, 0);
        add(BZ,  0, 59, 2, 23,  0,  5, 30, 0, 7, 59, 0);
        add(BO,  0, 59, 0, 23,  0, 23,  0, 1, 7, 59, 0);
        add(BZ,  0, 59, 0, 23,  0, 23,  0, 0, 7, 59, 0);
        // out-of-range readback clamps to 0; full MODE cycle discards
        add(BM, 30, 61, 1,  0,  0, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 1,  0,  0, 23,  0, 0, 7, 59, 0);
        add(BM, 30, 61, 2,  0,  0, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 2,  0,  0, 23,  0, 0, 7, 59, 0);
        add(BM, 30, 61, 3,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 3,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BM, 30, 61, 4,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 4,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BM, 30, 61, 0,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 0,  7, 59, 23,  0, 0, 7, 59, 0);
        // OK and UP ignored in IDLE
        add(BO, 30, 61, 0,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 0,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BU, 30, 61, 0,  7, 59, 23,  0, 0, 7, 59, 0);
        add(BZ, 30, 61, 0,  7, 59, 23,  0, 0, 7, 59, 0);

        // reset state
        cyc(BZ, 0, 0, 1'b1);
        cyc(BZ, 0, 0, 1'b1);
        cmp_reset_vals("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].btn, vecs[i].ch, vecs[i].cm, 1'b0);
            check($sformatf("v%0d_state", i), EDIT_STATE, vecs[i].st);
            check($sformatf("v%0d_edit_h", i), EDIT_HORAS, vecs[i].eh);
            check($sformatf("v%0d_edit_m", i), EDIT_MINUTOS, vecs[i].em);
            check($sformatf("v%0d_ihoras", i), IHORAS, vecs[i].ih);
            check($sformatf("v%0d_imin", i), IMINUTOS, vecs[i].im);
            check($sformatf("v%0d_set_hora", i), SET_HORA, vecs[i].set);
            check($sformatf("v%0d_thoras", i), THORAS, vecs[i].th);
            check($sformatf("v%0d_tmin", i), TMINUTOS, vecs[i].tm);
            check($sformatf("v%0d_alm_upd", i), ALM_UPD, vecs[i].alm);
        end

        // inactivity timeout: last press is the UP; expiry exactly TO cycles later
        cyc(BM, 12, 34, 1'b0);
        cyc(BZ, 12, 34, 1'b0);
        cyc(BU, 12, 34, 1'b0);
        check("to_edit_h", EDIT_HORAS, 13);
        strobes = 0;
        repeat (TO - 1) begin
            cyc(BZ, 12, 34, 1'b0);
            strobes += int'(SET_HORA) + int'(ALM_UPD);
        end
        check("to_before_expiry", EDIT_STATE, 1);
        cyc(BZ, 12, 34, 1'b0);
        strobes += int'(SET_HORA) + int'(ALM_UPD);
        check("to_expired", EDIT_STATE, 0);
        check("to_ihoras", IHORAS, 23);
        check("to_imin", IMINUTOS, 0);
        check("to_strobes", strobes, 0);

        // reset mid-edit
        cyc(BM, 12, 34, 1'b0);
        cyc(BZ, 12, 34, 1'b0);
        cyc(BU, 12, 34, 1'b0);
        cyc(BZ, 12, 34, 1'b1);
        cmp_reset_vals("rst_mid");
        cyc(BZ, 12, 34, 1'b0);
        check("rst_after_state", EDIT_STATE, 0);

        // OK coinciding with RESET must not strobe
        cyc(BM, 3, 4, 1'b0);
        cyc(BZ, 3, 4, 1'b0);
        cyc(BO, 3, 4, 1'b1);
        check("rst_ok_set_hora", SET_HORA, 0);
        check("rst_ok_ihoras", IHORAS, 0);
        cyc(BZ, 3, 4, 1'b0);
        cyc(BM, 3, 4, 1'b0); cyc(BZ, 3, 4, 1'b0);
        cyc(BM, 3, 4, 1'b0); cyc(BZ, 3, 4, 1'b0);
        cyc(BM, 3, 4, 1'b0); cyc(BZ, 3, 4, 1'b0);
        check("alm_entry_state", EDIT_STATE, 3);
        cyc(BO, 3, 4, 1'b1);
        check("rst_ok_alm_upd", ALM_UPD, 0);
        check("rst_ok_thoras", THORAS, 6);
        cyc(BZ, 3, 4, 1'b0);

        // hold UP in SET_M starting from minute 0
        cyc(BM, 0, 0, 1'b0); cyc(BZ, 0, 0, 1'b0);
        cyc(BM, 0, 0, 1'b0); cyc(BZ, 0, 0, 1'b0);
        cyc(BU, 0, 0, 1'b0);
        check("hold_first_step", EDIT_MINUTOS, 1);
`ifdef TIME_SET_AUTO_REPEAT_EN
        repeat (DLY - 1) cyc(BU, 0, 0, 1'b0);
        check("hold_before_delay", EDIT_MINUTOS, 1);
        cyc(BU, 0, 0, 1'b0);
        check("hold_first_repeat", EDIT_MINUTOS, 2);
        repeat (3 * RATE) cyc(BU, 0, 0, 1'b0);
        check("hold_repeat_total", EDIT_MINUTOS, 5);
`else
        repeat (DLY + 3 * RATE) cyc(BU, 0, 0, 1'b0);
        check("hold_no_repeat", EDIT_MINUTOS, 1);
`endif
        cyc(BZ, 0, 0, 1'b0);
        cyc(BO, 0, 0, 1'b0);
        check("hold_commit_imin", IMINUTOS, int'(EDIT_MINUTOS) == 0 ? 0 : m_im);
        cyc(BZ, 0, 0, 1'b0);

        // random activity against the model
        cyc(BZ, 0, 0, 1'b1);
        rb = 4'b0000; rch = 0; rcm = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) rb[k] = ~rb[k];
            end
            if ($urandom_range(0, 3) == 0) begin
                rch = $urandom_range(0, 63);
                rcm = $urandom_range(0, 63);
            end
            cyc(rb, rch, rcm, ($urandom_range(0, 499) == 0));
            cmp_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Button-driven front end that produces the time-load and alarm-target inputs of the running clock counter: IHORAS/IMINUTOS/SET_HORA and THORAS/TMINUTOS.
- Sits between the board push-buttons (already synchronised to CLK) and the clock/alarm block.
- Reads back the current time through CUR_HORAS/CUR_MINUTOS to preload edits.
- Implemented as a mode FSM, per-button edge/auto-repeat logic, wrap-around edit counters and an inactivity timeout.

Parameters:
- REPEAT_DELAY, 50, cycles UP/DOWN must stay held after the first step before auto-repeat starts.
- REPEAT_RATE, 10, cycles between auto-repeat steps.
- TIMEOUT, 1000, cycles with no button event before edit mode is abandoned.
- ALARM_H_RST, 6, reset value of THORAS.
- ALARM_M_RST, 0, reset value of TMINUTOS.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- BTN_MODE  in  1  mode/next-field button, level, synchronous
- BTN_UP  in  1  increment button
- BTN_DOWN  in  1  decrement button
- BTN_OK  in  1  commit button
- CUR_HORAS  in  6  running hour, 0..23
- CUR_MINUTOS  in  6  running minute, 0..59
- IHORAS  out  6  hour to load into the clock
- IMINUTOS  out  6  minute to load into the clock
- SET_HORA  out  1  one-cycle load strobe to the clock
- THORAS  out  6  alarm target hour
- TMINUTOS  out  6  alarm target minute
- ALM_UPD  out  1  one-cycle strobe when the alarm target changes
- EDIT_STATE  out  3  current FSM state, for display blanking
- EDIT_HORAS  out  6  hour value being edited
- EDIT_MINUTOS  out  6  minute value being edited

Behaviour:
- Interface: one clock, CLK; RESET is synchronous and active-high.
- Reset values: IHORAS=0, IMINUTOS=0, SET_HORA=0, THORAS=ALARM_H_RST, TMINUTOS=ALARM_M_RST, ALM_UPD=0, EDIT_*=0, state IDLE, all counters 0.
- Button events:
  - Each button has a registered previous sample. A press is current=1 while previous=0.
  - All actions take effect at the same posedge the press is sampled; outputs are registered.
- Priority when presses coincide: OK > MODE > UP/DOWN. UP and DOWN pressed together produce no step.
- States: IDLE=0, SET_H=1, SET_M=2, ALM_H=3, ALM_M=4.
- Transitions:
  - IDLE + MODE -> SET_H; EDIT_HORAS/EDIT_MINUTOS <= CUR_HORAS/CUR_MINUTOS. UP/DOWN/OK ignored in IDLE.
  - SET_H + MODE -> SET_M. SET_M + MODE -> ALM_H; the time edit is discarded and EDIT_* <= THORAS/TMINUTOS.
  - ALM_H + MODE -> ALM_M. ALM_M + MODE -> IDLE, discarding the edit.
  - OK in SET_H or SET_M: IHORAS/IMINUTOS <= EDIT_*; SET_HORA=1 for exactly that one cycle; -> IDLE.
  - OK in ALM_H or ALM_M: THORAS/TMINUTOS <= EDIT_*; ALM_UPD=1 for one cycle; -> IDLE.
- Edit arithmetic:
  - UP/DOWN act on the hour field in SET_H/ALM_H and the minute field in SET_M/ALM_M.
  - Hour wraps 23->0 on UP and 0->23 on DOWN.
  - Minute wraps 59->0 on UP and 0->59 on DOWN.
  - Out-of-range CUR_* (>23, >59) is clamped to 0 on preload.
- Timeout:
  - Counter clears on any press and whenever in IDLE.
  - In any edit state, reaching TIMEOUT cycles with no press -> IDLE, edit discarded, no strobe.
- Outputs that have not been committed hold their values indefinitely.
- RESET mid-edit: returns to IDLE with reset values. No SET_HORA or ALM_UPD is emitted in the reset cycle.

Optional Feature:
- TIME_SET_AUTO_REPEAT_EN defined:
  - Holding UP or DOWN steps once on the press.
  - After REPEAT_DELAY held cycles it steps again, then every REPEAT_RATE cycles while held.
  - Each repeat step also clears the timeout counter.
  - Releasing the button clears the repeat counter.
- Not defined: one step per press only; the repeat counters are absent.

Decomposition:
- Shared package:
  - state encoding constants IDLE..ALM_M;
  - MAX_HORA=23, MAX_MIN=59;
  - a 6-bit time-field typedef.
- Sub-module btn_edge_repeat, instantiated once per UP and DOWN:
  - contains the previous-sample register, the press pulse and the optional repeat counter;
  - MODE and OK use only its edge path.

Test Plan:
- RESET, then check outputs -> THORAS=6, TMINUTOS=0, SET_HORA=0, EDIT_STATE=0.
- CUR=23:59, MODE, UP, OK -> EDIT_HORAS 23->0; IHORAS=0, IMINUTOS=59; SET_HORA high exactly 1 cycle; EDIT_STATE=0.
- MODE, MODE, DOWN at minute 0, OK -> IMINUTOS=59, IHORAS=CUR_HORAS, single SET_HORA pulse.
- MODE x3, UP, MODE, DOWN, OK from alarm 06:00 -> THORAS=7, TMINUTOS=59, ALM_UPD pulse, SET_HORA stays 0.
- Enter SET_H, UP, then idle TIMEOUT cycles -> EDIT_STATE=0, IHORAS unchanged, no strobes. Repeat with RESET asserted mid-edit -> same result.
- With macro, hold UP in SET_M for REPEAT_DELAY+3*REPEAT_RATE cycles from 0 -> EDIT_MINUTOS=5. UP+DOWN pressed together -> no change. OK+MODE pressed together -> commit.
